// File: rtl/cond_logic_pkg.sv
// Shared processor definitions: ARM condition codes, flag bit positions, widths.
package cond_logic_pkg;

    localparam int unsigned COND_W  = 4;
    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned CNT_W   = 32;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Combinational ARM condition evaluation of Cond against the current flags.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] Flags,
    output logic               CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Decode the condition field; NV never executes.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: flag register, registered CondEx, gated strobes, statistics.
module cond_logic
    import cond_logic_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] ALUFlags,
    input  logic [1:0]         FlagW,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               CntClr,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [FLAGS_W-1:0] Flags,
    output logic [CNT_W-1:0]   CommitCnt,
    output logic [CNT_W-1:0]   SquashCnt
);

    logic               cond_ex;
    logic               cond_ex_q;
    logic [FLAGS_W-1:0] flags_q,      flags_d;
    logic [CNT_W-1:0]   commit_cnt_q, commit_cnt_d;
    logic [CNT_W-1:0]   squash_cnt_q, squash_cnt_d;
    logic               commit;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    assign commit = RegW | MemW | PCS;

    // Flag update uses CondEx from the pre-update flags, so a write is visible next cycle.
    always_comb begin
        flags_d = flags_q;
        if (FlagW[1] && cond_ex) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (FlagW[0] && cond_ex) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
    end

    // Statistics: clear wins over increment; counters wrap naturally.
    always_comb begin
        commit_cnt_d = commit_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (CntClr) begin
            commit_cnt_d = '0;
            squash_cnt_d = '0;
        end else if (commit) begin
            if (cond_ex_q) begin
                commit_cnt_d = commit_cnt_q + CNT_W'(1);
            end else begin
                squash_cnt_d = squash_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q      <= '0;
            cond_ex_q    <= 1'b0;
            commit_cnt_q <= '0;
            squash_cnt_q <= '0;
        end else begin
            flags_q      <= flags_d;
            cond_ex_q    <= cond_ex;
            commit_cnt_q <= commit_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign PCWrite   = NextPC | (PCS & cond_ex_q);
    assign RegWrite  = RegW & cond_ex_q;
    assign MemWrite  = MemW & cond_ex_q;
    assign Flags     = flags_q;
    assign CommitCnt = commit_cnt_q;
    assign SquashCnt = squash_cnt_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic.
module tb_cond_logic;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, NextPC, RegW, MemW, CntClr;
    logic        PCWrite, RegWrite, MemWrite;
    logic [3:0]  Flags;
    logic [31:0] CommitCnt, SquashCnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_logic dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .CntClr    (CntClr),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .Flags     (Flags),
        .CommitCnt (CommitCnt),
        .SquashCnt (SquashCnt)
    );

    // Reference condition evaluation: pairs of conditions, odd code is the inverse.
    function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: return ~c[0];
        endcase
        return c[0] ? ~b : b;
    endfunction

    task automatic test_reset();
        reset = 1'b0; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hF; CntClr = 1'b0;
        #2;
        for (int pass = 0; pass < 2; pass++) begin
            total++; if (PCWrite !== 1'b1) begin bad++; $display("FAIL reset_pcwrite act=%b req=1", PCWrite); end
            total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite act=%b req=0", RegWrite); end
            total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL reset_memwrite act=%b req=0", MemWrite); end
            total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags act=%b req=0000", Flags); end
            total++; if (CommitCnt !== 32'd0) begin bad++; $display("FAIL reset_commit act=%0d req=0", CommitCnt); end
            total++; if (SquashCnt !== 32'd0) begin bad++; $display("FAIL reset_squash act=%0d req=0", SquashCnt); end
            @(negedge clk);
        end
        NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
        Cond = 4'hF; FlagW = 2'b00; ALUFlags = 4'h0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flags_eq();
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100;
        @(negedge clk);
        total++; if (Flags !== 4'b0100) begin bad++; $display("FAIL eq_flags act=%b req=0100", Flags); end
        Cond = 4'h0; FlagW = 2'b00; ALUFlags = 4'h0;
        @(negedge clk);
        RegW = 1'b1; Cond = 4'hF;
        #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL eq_regwrite act=%b req=1", RegWrite); end
        @(negedge clk);
        RegW = 1'b0;
        total++; if (CommitCnt !== 32'd1) begin bad++; $display("FAIL eq_commit act=%0d req=1", CommitCnt); end
        total++; if (SquashCnt !== 32'd0) begin bad++; $display("FAIL eq_squash act=%0d req=0", SquashCnt); end
    endtask

    task automatic test_squash();
        Cond = 4'h1;
        @(negedge clk);
        MemW = 1'b1; Cond = 4'hF;
        #1;
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL ne_memwrite act=%b req=0", MemWrite); end
        @(negedge clk);
        MemW = 1'b0;
        total++; if (SquashCnt !== 32'd1) begin bad++; $display("FAIL ne_squash act=%0d req=1", SquashCnt); end
        total++; if (CommitCnt !== 32'd1) begin bad++; $display("FAIL ne_commit act=%0d req=1", CommitCnt); end
        total++; if (Flags !== 4'b0100) begin bad++; $display("FAIL ne_flags act=%b req=0100", Flags); end
        Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b1011;
        @(negedge clk);
        total++; if (Flags !== 4'b0100) begin bad++; $display("FAIL ne_flagw act=%b req=0100", Flags); end
        Cond = 4'hE; FlagW = 2'b01; ALUFlags = 4'b1011;
        @(negedge clk);
        total++; if (Flags !== 4'b0111) begin bad++; $display("FAIL flagw_cv act=%b req=0111", Flags); end
        FlagW = 2'b10; ALUFlags = 4'b1000;
        @(negedge clk);
        total++; if (Flags !== 4'b1011) begin bad++; $display("FAIL flagw_nz act=%b req=1011", Flags); end
        FlagW = 2'b11; ALUFlags = 4'b0100;
        @(negedge clk);
        // EQ sees Z=1 before the same-cycle write clears it.
        Cond = 4'h0; FlagW = 2'b10; ALUFlags = 4'b0000;
        @(negedge clk);
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL same_cycle_flags act=%b req=0000", Flags); end
        FlagW = 2'b00; RegW = 1'b1;
        #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL same_cycle_old act=%b req=1", RegWrite); end
        @(negedge clk);
        Cond = 4'hF;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL same_cycle_new act=%b req=0", RegWrite); end
        RegW = 1'b0;
    endtask

    task automatic test_pcwrite();
        Cond = 4'hF;
        @(negedge clk);
        PCS = 1'b1; NextPC = 1'b0;
        #1;
        total++; if (PCWrite !== 1'b0) begin bad++; $display("FAIL pcs_squashed act=%b req=0", PCWrite); end
        NextPC = 1'b1;
        #1;
        total++; if (PCWrite !== 1'b1) begin bad++; $display("FAIL nextpc act=%b req=1", PCWrite); end
        Cond = 4'hE;
        @(negedge clk);
        NextPC = 1'b0;
        #1;
        total++; if (PCWrite !== 1'b1) begin bad++; $display("FAIL pcs_taken act=%b req=1", PCWrite); end
        PCS = 1'b0;
        #1;
        total++; if (PCWrite !== 1'b0) begin bad++; $display("FAIL pc_idle act=%b req=0", PCWrite); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL regw_low act=%b req=0", RegWrite); end
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL memw_low act=%b req=0", MemWrite); end
        MemW = 1'b1;
        #1;
        total++; if (MemWrite !== 1'b1) begin bad++; $display("FAIL memw_taken act=%b req=1", MemWrite); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL regw_isolated act=%b req=0", RegWrite); end
        MemW = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_table();
        logic [3:0] f4, c4;
        CntClr = 1'b1; RegW = 1'b1;
        for (int f = 0; f < 16; f++) begin
            f4 = 4'(f);
            Cond = 4'hE; FlagW = 2'b11; ALUFlags = f4;
            @(negedge clk);
            FlagW = 2'b00;
            total++; if (Flags !== f4) begin bad++; $display("FAIL table_flags act=%b req=%b", Flags, f4); end
            for (int c = 0; c < 16; c++) begin
                c4 = 4'(c);
                Cond = c4;
                @(negedge clk);
                total++;
                if (RegWrite !== exp_cond(c4, f4)) begin
                    bad++;
                    $display("FAIL table cond=%b flags=%b act=%b req=%b", c4, f4, RegWrite, exp_cond(c4, f4));
                end
            end
        end
        RegW = 1'b0; Cond = 4'hF;
        @(negedge clk);
        total++; if (CommitCnt !== 32'd0) begin bad++; $display("FAIL clr_commit act=%0d req=0", CommitCnt); end
        total++; if (SquashCnt !== 32'd0) begin bad++; $display("FAIL clr_squash act=%0d req=0", SquashCnt); end
        CntClr = 1'b0;
    endtask

    task automatic test_wrap();
        Cond = 4'hE; RegW = 1'b0; CntClr = 1'b1;
        @(negedge clk);
        CntClr = 1'b0;
        force dut.commit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_cnt_q;
        RegW = 1'b1;
        @(negedge clk);
        total++; if (CommitCnt !== 32'd0) begin bad++; $display("FAIL wrap_commit act=%h req=00000000", CommitCnt); end
        total++; if (SquashCnt !== 32'd0) begin bad++; $display("FAIL wrap_squash act=%h req=00000000", SquashCnt); end
        @(negedge clk);
        total++; if (CommitCnt !== 32'd1) begin bad++; $display("FAIL after_wrap act=%0d req=1", CommitCnt); end
        CntClr = 1'b1;
        @(negedge clk);
        total++; if (CommitCnt !== 32'd0) begin bad++; $display("FAIL clr_priority act=%0d req=0", CommitCnt); end
        CntClr = 1'b0; RegW = 1'b0;
    endtask

    task automatic test_async_reset();
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1010;
        @(negedge clk);
        FlagW = 2'b00; ALUFlags = 4'h0;
        total++; if (Flags !== 4'b1010) begin bad++; $display("FAIL pre_reset_flags act=%b req=1010", Flags); end
        RegW = 1'b1; PCS = 1'b1;
        #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL pre_reset_regwrite act=%b req=1", RegWrite); end
        #1 reset = 1'b0;
        #1;
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL async_flags act=%b req=0000", Flags); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL async_condexd act=%b req=0", RegWrite); end
        total++; if (PCWrite !== 1'b0) begin bad++; $display("FAIL async_pcwrite act=%b req=0", PCWrite); end
        total++; if (CommitCnt !== 32'd0) begin bad++; $display("FAIL async_commit act=%0d req=0", CommitCnt); end
        @(negedge clk);
        reset = 1'b1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL post_reset_hold act=%b req=0", RegWrite); end
        @(negedge clk);
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL post_reset_capture act=%b req=1", RegWrite); end
        RegW = 1'b0; PCS = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_flags_eq();
        test_squash();
        test_pcwrite();
        test_table();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
